// File: rtl/usart_fifo_core.sv
// UART transceiver with TX/RX FIFOs, valid/ready on the system side.
// Optional parity bit enabled by defining USART_PARITY_EN.

module usart_fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          do_push, do_pop;

    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    // A pop in the same cycle frees the slot, so a push into a full FIFO can still land.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + PW'(do_push);
        rd_d = rd_q + PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// state    | meaning
// S_IDLE   | line idle, waiting for work / start edge
// S_START  | start bit
// S_DATA   | DATA_BITS payload bits, LSB first
// S_PARITY | parity bit (only reachable with USART_PARITY_EN)
// S_STOP   | stop bit(s)
module usart_fifo_core #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_ODD     = 0,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 tx,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 tx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
`ifdef USART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    localparam int   TW      = $clog2(CLOCKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLOCKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // TX side
    state_t               tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_timer_q, tx_timer_d;
    logic [3:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tf_pop, tf_full, tf_empty;
    logic [DATA_BITS-1:0] tf_rdata;

    usart_fifo_sync #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && tx_ready),
        .wdata (tx_data),
        .pop   (tf_pop),
        .rdata (tf_rdata),
        .full  (tf_full),
        .empty (tf_empty)
    );

    assign tx_ready = !tf_full;
    assign tx_busy  = (tx_state_q != S_IDLE) || !tf_empty;
    assign tx       = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = (tx_timer_q == T_LAST) ? '0 : tx_timer_q + TW'(1);
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = 1'b1;
        tf_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_timer_d = '0;
                if (!tf_empty) begin
                    tf_pop     = 1'b1;
                    tx_shift_d = tf_rdata;
                    tx_par_d   = ^tf_rdata ^ PAR_ODD;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (tx_timer_q == T_LAST) begin
                    tx_idx_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = tx_shift_q[0];
                if (tx_timer_q == T_LAST) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == D_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                tx_d = tx_par_q;
                if (tx_timer_q == T_LAST) begin
                    tx_idx_d   = '0;
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_timer_q == T_LAST) begin
                    if (tx_idx_q == S_LAST) begin
                        tx_idx_d = '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (!tf_empty) begin
                            tf_pop     = 1'b1;
                            tx_shift_d = tf_rdata;
                            tx_par_d   = ^tf_rdata ^ PAR_ODD;
                            tx_state_d = S_START;
                        end else begin
                            tx_state_d = S_IDLE;
                        end
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_timer_q <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    // RX side
    state_t               rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_timer_q, rx_timer_d;
    logic [3:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_pbad_q, rx_pbad_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
    logic                 rf_push, rf_pop, rf_full, rf_empty;

    usart_fifo_sync #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rf_push),
        .wdata (rx_shift_q),
        .pop   (rf_pop),
        .rdata (rx_data),
        .full  (rf_full),
        .empty (rf_empty)
    );

    assign rx_valid      = !rf_empty;
    assign rf_pop        = rx_valid && rx_ready;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_q;
    assign rx_overrun    = ovr_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q + TW'(1);
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_pbad_d  = rx_pbad_q;
        rf_push    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        ovr_d      = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_timer_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_timer_q == T_HALF) begin
                    rx_timer_d = '0;
                    rx_idx_d   = '0;
                    rx_pbad_d  = 1'b0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_timer_q == T_LAST) begin
                    rx_timer_d = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == D_LAST) begin
                        rx_idx_d   = '0;
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_timer_q == T_LAST) begin
                    rx_timer_d = '0;
                    rx_pbad_d  = PAR_EN && ((^rx_shift_q ^ rx_s2_q) != PAR_ODD);
                    perr_d     = rx_pbad_d;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_timer_q == T_LAST) begin
                    rx_timer_d = '0;
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (!rx_pbad_q) begin
                        rf_push = 1'b1;
                        ovr_d   = rf_full && !rf_pop;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_timer_q <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_pbad_q  <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_pbad_q  <= rx_pbad_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end
endmodule
